// File: rtl/br_arb_wrr_pkg.sv
// Shared helpers for the packet-atomic weighted round-robin arbiter:
// index-width calculation and per-flow weight extraction from the packed weight bus.
package br_arb_wrr_pkg;

    // The weight bus is widened to this container before slicing, so
    // NumFlows*WeightWidth must not exceed it.
    localparam int MaxWeightVecBits = 1024;

    typedef logic [MaxWeightVecBits-1:0] weight_vec_t;
    typedef logic [31:0]                 weight_word_t;

    // Width of a flow index; a single flow still needs a 1-bit index.
    function automatic int idx_width(input int num_flows);
        return (num_flows > 1) ? $clog2(num_flows) : 1;
    endfunction

    // Returns weight[idx] from a packed vector of 'width'-bit weights.
    function automatic weight_word_t weight_at(input weight_vec_t vec,
                                               input int          idx,
                                               input int          width);
        weight_word_t mask;
        mask = (weight_word_t'(1) << width) - weight_word_t'(1);
        return weight_word_t'(vec >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/br_arb_wrr_packet_if.sv
// Arbiter <-> flow-controlled mux core handshake bundle.
// The mux core is the master; the arbiter is the slave.
interface br_arb_wrr_packet_if #(
    parameter int NumFlows = 2
);
    logic [NumFlows-1:0] request;
    logic [NumFlows-1:0] request_last;
    logic                enable_priority_update;
    logic [NumFlows-1:0] can_grant;
    logic [NumFlows-1:0] grant;

    modport master (
        output request,
        output request_last,
        output enable_priority_update,
        input  can_grant,
        input  grant
    );

    modport slave (
        input  request,
        input  request_last,
        input  enable_priority_update,
        output can_grant,
        output grant
    );
endinterface

// File: rtl/br_arb_wrr_packet_select.sv
// Rotating priority encoder: scans from ptr (wrapping) and picks the first
// eligible flow; can_grant also covers idle positions ranked ahead of the winner.
module br_arb_wrr_packet_select
    import br_arb_wrr_pkg::*;
#(
    parameter int NumFlows = 2,
    parameter int IdxW     = idx_width(NumFlows)
) (
    input  logic [IdxW-1:0]     ptr,
    input  logic [NumFlows-1:0] request,
    input  logic [NumFlows-1:0] eligible,
    output logic                found,
    output logic [IdxW-1:0]     winner,
    output logic [NumFlows-1:0] can_grant
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] idx;

    // NOTE: every signal written here gets a default before the loop, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        can_grant = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NumFlows; k++) begin
            sum = {1'b0, ptr} + (IdxW+1)'(k);
            if (sum >= (IdxW+1)'(NumFlows)) begin
                sum = sum - (IdxW+1)'(NumFlows);
            end
            idx = sum[IdxW-1:0];
            if (!found) begin
                if (eligible[idx]) begin
                    found          = 1'b1;
                    winner         = idx;
                    can_grant[idx] = 1'b1;
                end else if (!request[idx]) begin
                    can_grant[idx] = 1'b1;
                end
            end
        end
        // Without a winner nobody is offered a grant.
        if (!found) begin
            can_grant = '0;
        end
    end

endmodule

// File: rtl/br_arb_wrr_packet.sv
// Packet-atomic weighted round-robin arbiter for a shared flow-controlled mux:
// holds a grant for a whole packet and allows up to weight[i] packets per round.
module br_arb_wrr_packet
    import br_arb_wrr_pkg::*;
#(
    parameter int NumFlows    = 2,
    parameter int WeightWidth = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NumFlows*WeightWidth-1:0] weight,
    br_arb_wrr_packet_if.slave              arb
);

    localparam int IdxW = idx_width(NumFlows);

    logic [IdxW-1:0]        ptr;
    logic                   locked;
    logic [IdxW-1:0]        lock_id;
    logic [WeightWidth-1:0] credit     [NumFlows];

    logic [WeightWidth-1:0] weight_arr [NumFlows];
    logic [WeightWidth-1:0] ecredit    [NumFlows];
    logic [NumFlows-1:0]    enabled;
    logic [NumFlows-1:0]    eligible;
    logic                   any_credit;

    logic                   open_found;
    logic [IdxW-1:0]        open_winner;
    logic [NumFlows-1:0]    open_can_grant;
    logic [NumFlows-1:0]    lock_onehot;

    logic [IdxW-1:0]        gnt_idx;
    logic [IdxW-1:0]        gnt_idx_inc;
    logic [WeightWidth-1:0] gnt_credit_next;
    logic                   fire;
    logic                   fire_last;

    // Effective credit: a round replenishes from weight once no requesting,
    // enabled flow has budget left; the replenish is committed on the next update.
    always_comb begin
        any_credit = 1'b0;
        for (int i = 0; i < NumFlows; i++) begin
            weight_arr[i] = WeightWidth'(weight_at(weight_vec_t'(weight), i, WeightWidth));
            enabled[i]    = (weight_arr[i] != '0);
            if (arb.request[i] && enabled[i] && (credit[i] != '0)) begin
                any_credit = 1'b1;
            end
        end
        for (int i = 0; i < NumFlows; i++) begin
            ecredit[i]  = any_credit ? credit[i] : weight_arr[i];
            eligible[i] = arb.request[i] && enabled[i] && (ecredit[i] != '0);
        end
    end

    br_arb_wrr_packet_select #(
        .NumFlows (NumFlows),
        .IdxW     (IdxW)
    ) u_select (
        .ptr       (ptr),
        .request   (arb.request),
        .eligible  (eligible),
        .found     (open_found),
        .winner    (open_winner),
        .can_grant (open_can_grant)
    );

    always_comb begin
        lock_onehot          = '0;
        lock_onehot[lock_id] = 1'b1;
    end

    // A locked flow keeps exclusive eligibility even while its request is low.
    always_comb begin
        arb.can_grant = '0;
        arb.grant     = '0;
        gnt_idx       = open_winner;
        if (locked) begin
            arb.can_grant = lock_onehot;
            arb.grant     = lock_onehot & arb.request;
            gnt_idx       = lock_id;
        end else begin
            arb.can_grant = open_can_grant;
            if (open_found) begin
                arb.grant[open_winner] = 1'b1;
            end
        end
    end

    assign fire      = arb.enable_priority_update && (|arb.grant);
    assign fire_last = fire && arb.request_last[gnt_idx];

    // Saturate so a lock taken on a replenish cannot wrap if the round later
    // resumes with this flow already drained.
    assign gnt_credit_next = (ecredit[gnt_idx] != '0) ? ecredit[gnt_idx] - 1'b1 : '0;
    assign gnt_idx_inc     = (gnt_idx == IdxW'(NumFlows - 1)) ? '0 : gnt_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
            // NOTE: credit is a handful of flops, not a RAM, so it is cleared
            // in reset like any other control register.
            for (int i = 0; i < NumFlows; i++) begin
                credit[i] <= '0;
            end
        end else if (fire) begin
            if (!fire_last) begin
                locked  <= 1'b1;
                lock_id <= gnt_idx;
            end else begin
                locked <= 1'b0;
                for (int i = 0; i < NumFlows; i++) begin
                    credit[i] <= (IdxW'(i) == gnt_idx) ? gnt_credit_next : ecredit[i];
                end
                // Exhausted flows hand priority on; others keep it for their next packet.
                ptr <= (gnt_credit_next == '0) ? gnt_idx_inc : gnt_idx;
            end
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(arb.grant));
    a_grant_subset: assert property (@(posedge clk) disable iff (rst)
        (arb.grant & ~arb.request) == '0);
    a_last_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(arb.request_last & arb.request));
    a_lock_stable: assert property (@(posedge clk) disable iff (rst)
        locked |=> $stable(lock_id));

    c_replenish: cover property (@(posedge clk) disable iff (rst)
        fire_last && !any_credit);
    c_ptr_wrap: cover property (@(posedge clk) disable iff (rst)
        (ptr == IdxW'(NumFlows - 1)) ##1 (ptr == '0));
    c_locked_stall: cover property (@(posedge clk) disable iff (rst)
        locked && !arb.request[lock_id]);
`endif

endmodule

// File: tb/tb_br_arb_wrr_packet.sv
// Directed self-checking bench for br_arb_wrr_packet with three flows;
// expected grant/can_grant values are hand-derived per vector.
module tb_br_arb_wrr_packet;

    localparam int NumFlows    = 3;
    localparam int WeightWidth = 4;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [NumFlows*WeightWidth-1:0] weight;

    int checks   = 0;
    int failures = 0;

    br_arb_wrr_packet_if #(.NumFlows(NumFlows)) arb_if ();

    br_arb_wrr_packet #(
        .NumFlows    (NumFlows),
        .WeightWidth (WeightWidth)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .weight (weight),
        .arb    (arb_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NumFlows-1:0] got,
                         input logic [NumFlows-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, check mid-cycle, then
    // let the edge commit.
    task automatic step(input string tag, input logic [2:0] req, input logic [2:0] last,
                        input logic epu, input logic [2:0] exp_grant,
                        input logic [2:0] exp_cg);
        arb_if.request                = req;
        arb_if.request_last           = last;
        arb_if.enable_priority_update = epu;
        #4;
        check({tag, ".grant"}, arb_if.grant, exp_grant);
        check({tag, ".can_grant"}, arb_if.can_grant, exp_cg);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NumFlows*WeightWidth-1:0] w);
        rst                           = 1'b1;
        weight                        = w;
        arb_if.request                = '0;
        arb_if.request_last           = '0;
        arb_if.enable_priority_update = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("reset.grant", arb_if.grant, 3'b000);
        check("reset.can_grant", arb_if.can_grant, 3'b000);
        rst = 1'b0;
    endtask

    logic [2:0] rr_exp   [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] w31_gnt  [8] = '{3'b001, 3'b001, 3'b001, 3'b010,
                                 3'b001, 3'b001, 3'b001, 3'b010};
    logic [2:0] w31_cg   [8] = '{3'b001, 3'b001, 3'b001, 3'b010,
                                 3'b101, 3'b001, 3'b001, 3'b010};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Equal weights, single-beat packets from everyone: plain round robin.
        do_reset(12'h111);
        step("rr.stall", 3'b111, 3'b111, 1'b0, 3'b001, 3'b001);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("rr.%0d", i), 3'b111, 3'b111, 1'b1, rr_exp[i], rr_exp[i]);
        end

        // Weights {3,1}, flow 2 disabled: 0,0,0,1 repeating.
        do_reset(12'h013);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("w31.%0d", i), 3'b011, 3'b011, 1'b1, w31_gnt[i], w31_cg[i]);
        end

        // Flow 1 four-beat packet, flow 0 joins from beat 2.
        do_reset(12'h111);
        step("pkt.b1", 3'b010, 3'b000, 1'b1, 3'b010, 3'b011);
        step("pkt.b2", 3'b011, 3'b000, 1'b1, 3'b010, 3'b010);
        step("pkt.b3", 3'b011, 3'b000, 1'b1, 3'b010, 3'b010);
        step("pkt.b4", 3'b011, 3'b010, 1'b1, 3'b010, 3'b010);
        step("pkt.next", 3'b001, 3'b001, 1'b1, 3'b001, 3'b101);

        // Locked flow 2 drops its request for three cycles.
        do_reset(12'h111);
        step("stall.b1", 3'b100, 3'b000, 1'b1, 3'b100, 3'b111);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall.gap%0d", i), 3'b011, 3'b011, 1'b1, 3'b000, 3'b100);
        end
        step("stall.b2", 3'b111, 3'b100, 1'b1, 3'b100, 3'b100);
        step("stall.next", 3'b011, 3'b011, 1'b1, 3'b001, 3'b001);

        // Weight 0 disables flow 0 even while it requests.
        do_reset(12'h020);
        step("w0.solo", 3'b001, 3'b001, 1'b1, 3'b000, 3'b000);
        step("w0.a", 3'b011, 3'b011, 1'b1, 3'b010, 3'b010);
        step("w0.b", 3'b011, 3'b011, 1'b1, 3'b010, 3'b010);
        step("w0.c", 3'b011, 3'b011, 1'b1, 3'b010, 3'b110);
        step("w0.solo2", 3'b001, 3'b001, 1'b1, 3'b000, 3'b000);

        // Reset in beat 2 of a flow 1 packet, with ptr and credit previously moved.
        do_reset(12'h111);
        step("rstpkt.pre", 3'b001, 3'b001, 1'b1, 3'b001, 3'b001);
        step("rstpkt.b1", 3'b010, 3'b000, 1'b1, 3'b010, 3'b010);
        rst = 1'b1;
        step("rstpkt.b2", 3'b010, 3'b000, 1'b1, 3'b010, 3'b010);
        rst = 1'b0;
        step("rstpkt.after", 3'b011, 3'b011, 1'b1, 3'b001, 3'b001);
        step("rstpkt.next", 3'b011, 3'b011, 1'b1, 3'b010, 3'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
